// File: rtl/mips_multicycle_if.sv
// Shared instruction/data memory port of the multicycle MIPS core.
// The core drives the request side; memory answers with readdata/memready.
interface mips_multicycle_if;
    logic [31:0] adr;
    logic        memread;
    logic        memwrite;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        memready;

    modport master (output adr, memread, memwrite, writedata, input readdata, memready);
    modport slave  (input adr, memread, memwrite, writedata, output readdata, memready);
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one ALU and one memory port, sequenced by the main FSM.
// Supports add/sub/and/or/slt, lw, sw, beq, addi, j; anything else pulses o_illegal.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    mips_multicycle_if.master        bus,
    output logic [31:0]              o_pc,
    output logic                     o_illegal
);
    localparam int RW = $clog2(NREGS);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_t;

    state_t        r_state, w_next;
    logic [31:0]   r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [31:0]   r_regs [NREGS];
    logic          r_illegal;
    logic          w_illegal;
    logic [5:0]    w_op, w_funct;
    logic [RW-1:0] w_rs, w_rt, w_rd;
    logic [31:0]   w_imm, w_rs_val, w_rt_val;
    logic          w_funct_ok;
    alu_t          w_funct_ctl, w_alu_ctl;
    logic [31:0]   w_alu_a, w_alu_b, w_alu_y;
    logic          w_rf_we;
    logic [RW-1:0] w_rf_wa;
    logic [31:0]   w_rf_wd;

    assign w_op      = r_ir[31:26];
    assign w_funct   = r_ir[5:0];
    assign w_rs      = r_ir[21 +: RW];
    assign w_rt      = r_ir[16 +: RW];
    assign w_rd      = r_ir[11 +: RW];
    assign w_imm     = {{16{r_ir[15]}}, r_ir[15:0]};
    assign w_rs_val  = (w_rs == {RW{1'b0}}) ? 32'd0 : r_regs[w_rs];
    assign w_rt_val  = (w_rt == {RW{1'b0}}) ? 32'd0 : r_regs[w_rt];
    assign o_pc      = r_pc;
    assign o_illegal = r_illegal;
    assign bus.writedata = r_b;

    // R-type funct decode
    always_comb begin
        w_funct_ok  = 1'b1;
        w_funct_ctl = ALU_ADD;
        case (w_funct)
            6'h20:   w_funct_ctl = ALU_ADD;
            6'h22:   w_funct_ctl = ALU_SUB;
            6'h24:   w_funct_ctl = ALU_AND;
            6'h25:   w_funct_ctl = ALU_OR;
            6'h2A:   w_funct_ctl = ALU_SLT;
            default: w_funct_ok  = 1'b0;
        endcase
    end

    // ALU operand routing: PC increment in FETCH, branch target in DECODE, A/B otherwise
    always_comb begin
        w_alu_a   = r_pc;
        w_alu_b   = 32'd4;
        w_alu_ctl = ALU_ADD;
        case (r_state)
            S_DECODE:           w_alu_b = {w_imm[29:0], 2'b00};
            S_MEMADR, S_ADDIEX: begin w_alu_a = r_a; w_alu_b = w_imm; end
            S_EXEC:             begin w_alu_a = r_a; w_alu_b = r_b; w_alu_ctl = w_funct_ctl; end
            S_BRANCH:           begin w_alu_a = r_a; w_alu_b = r_b; w_alu_ctl = ALU_SUB; end
            default:            w_alu_ctl = ALU_ADD;
        endcase
    end

    // Shared ALU
    always_comb begin
        case (w_alu_ctl)
            ALU_ADD: w_alu_y = w_alu_a + w_alu_b;
            ALU_SUB: w_alu_y = w_alu_a - w_alu_b;
            ALU_AND: w_alu_y = w_alu_a & w_alu_b;
            ALU_OR:  w_alu_y = w_alu_a | w_alu_b;
            ALU_SLT: w_alu_y = {31'd0, $signed(w_alu_a) < $signed(w_alu_b)};
            default: w_alu_y = w_alu_a + w_alu_b;
        endcase
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, memory request and register writeback selection
    always_comb begin
        w_next        = r_state;
        w_illegal     = 1'b0;
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.adr       = r_aluout;
        w_rf_we       = 1'b0;
        w_rf_wa       = w_rt;
        w_rf_wd       = r_aluout;
        case (r_state)
            S_FETCH: begin
                bus.memread = 1'b1;
                bus.adr     = r_pc;
                if (bus.memready) begin
                    w_next = S_DECODE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                case (w_op)
                    6'h00: begin
                        if (w_funct_ok) begin
                            w_next = S_EXEC;
                        end else begin
                            w_next    = S_FETCH;
                            w_illegal = 1'b1;
                        end
                    end
                    6'h23, 6'h2B: w_next = S_MEMADR;
                    6'h04:        w_next = S_BRANCH;
                    6'h08:        w_next = S_ADDIEX;
                    6'h02:        w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: w_next = (w_op == 6'h23) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                bus.memread = 1'b1;
                w_next      = bus.memready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                w_rf_we = 1'b1;
                w_rf_wd = r_mdr;
                w_next  = S_FETCH;
            end
            S_MEMWR: begin
                // A store still pending when reset arrives must not reach memory
                bus.memwrite = ~i_reset;
                w_next       = bus.memready ? S_FETCH : S_MEMWR;
            end
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB: begin
                w_rf_we = 1'b1;
                w_rf_wa = w_rd;
                w_next  = S_FETCH;
            end
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: begin
                w_rf_we = 1'b1;
                w_next  = S_FETCH;
            end
            S_JUMP:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    // Datapath registers and register file
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_aluout  <= 32'd0;
            r_mdr     <= 32'd0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_illegal <= w_illegal;
            case (r_state)
                S_FETCH: begin
                    if (bus.memready) begin
                        r_ir <= bus.readdata;
                        r_pc <= w_alu_y;
                    end
                end
                S_DECODE: begin
                    r_a      <= w_rs_val;
                    r_b      <= w_rt_val;
                    r_aluout <= w_alu_y;
                end
                S_MEMADR, S_EXEC, S_ADDIEX: r_aluout <= w_alu_y;
                S_MEMRD: begin
                    if (bus.memready) begin
                        r_mdr <= bus.readdata;
                    end
                end
                S_BRANCH: begin
                    if (w_alu_y == 32'd0) begin
                        r_pc <= r_aluout;
                    end
                end
                S_JUMP:  r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default: r_pc <= r_pc;
            endcase
            if (w_rf_we && (w_rf_wa != {RW{1'b0}})) begin
                r_regs[w_rf_wa] <= w_rf_wd;
            end
        end
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// Self-checking bench for mips_multicycle: an instruction-level reference model
// predicts each instruction's fetch, memory traffic, latency and resulting PC.
module tb_mips_multicycle;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        illegal;
    logic        ld_en;
    logic [8:0]  ld_a;
    logic [31:0] ld_d;
    logic [31:0] dmem [512];
    logic [31:0] mmem [512];
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;
    logic        m_ill;
    logic [31:0] gen_a;
    logic [31:0] end_pc;
    logic [5:0]  fn_tab [5];
    int          checks = 0;
    int          failures = 0;

    mips_multicycle_if bus ();

    mips_multicycle #(.RESET_PC(32'h0000_0000), .NREGS(32)) dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .bus      (bus),
        .o_pc     (pc),
        .o_illegal(illegal)
    );

    always #5 clk = ~clk;

    assign bus.readdata = bus.memready ? dmem[bus.adr[10:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (ld_en) dmem[ld_a] <= ld_d;
        else if (bus.memwrite && bus.memready) dmem[bus.adr[10:2]] <= bus.writedata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic emit(input logic [31:0] w);
        mmem[gen_a[10:2]] = w;
        gen_a = gen_a + 32'd4;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pc  = 32'd0;
        m_ill = 1'b0;
    endtask

    // Runs one instruction against the model; entered and left at the negedge of a fetch cycle.
    task automatic exec_one(input int fw, input int mw);
        logic [31:0] ins, se, npc, acc_adr, acc_dat, wval, a, b;
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, widx;
        int          lat, acc, ac, total;
        logic        wen, ill;
        ins = mmem[m_pc[10:2]];
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
        se = {{16{ins[15]}}, ins[15:0]};
        a = m_regs[rs]; b = m_regs[rt];
        npc = m_pc + 32'd4; acc = 0; acc_adr = 32'd0; acc_dat = 32'd0;
        wen = 1'b0; widx = rt; wval = 32'd0; ill = 1'b0; lat = 4;
        case (op)
            6'h00: begin
                widx = rd; wen = 1'b1;
                case (fn)
                    6'h20: wval = a + b;
                    6'h22: wval = a - b;
                    6'h24: wval = a & b;
                    6'h25: wval = a | b;
                    6'h2A: wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    default: begin wen = 1'b0; ill = 1'b1; lat = 2; end
                endcase
            end
            6'h23: begin lat = 5; acc = 1; acc_adr = a + se; wen = 1'b1; wval = mmem[acc_adr[10:2]]; end
            6'h2B: begin acc = 2; acc_adr = a + se; acc_dat = b; end
            6'h04: begin lat = 3; if (a == b) npc = npc + (se << 2); end
            6'h08: begin wen = 1'b1; wval = a + se; end
            6'h02: begin lat = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
            default: begin ill = 1'b1; lat = 2; end
        endcase
        total = lat + fw + ((acc != 0) ? mw : 0);
        ac = 0;
        for (int k = 0; k < total; k++) begin
            chk1("rw_exclusive", bus.memread & bus.memwrite, 1'b0);
            chk1("illegal", illegal, (k == 0) ? m_ill : 1'b0);
            if (k <= fw) begin
                chk1("fetch_memread", bus.memread, 1'b1);
                chk1("fetch_memwrite", bus.memwrite, 1'b0);
                chk("fetch_adr", bus.adr, m_pc);
                if (k == 0) chk("pc", pc, m_pc);
                bus.memready = (k == fw);
            end else begin
                if (k == fw + 1) chk("pc_incr", pc, m_pc + 32'd4);
                if (bus.memread || bus.memwrite) begin
                    ac++;
                    chk1("acc_read", bus.memread, acc == 1);
                    chk1("acc_write", bus.memwrite, acc == 2);
                    chk("acc_adr", bus.adr, acc_adr);
                    if (acc == 2) chk("store_data", bus.writedata, acc_dat);
                    bus.memready = (ac > mw);
                end else begin
                    bus.memready = 1'b1;
                end
            end
            @(negedge clk);
        end
        chk("access_cycles", ac, (acc != 0) ? mw + 1 : 0);
        if (wen && widx != 5'd0) m_regs[widx] = wval;
        if (acc == 2) mmem[acc_adr[10:2]] = acc_dat;
        m_pc  = npc;
        m_ill = ill;
    endtask

    initial begin
        int n, fw, mw, kind;
        logic [4:0] r1, r2, r3;
        reset = 1'b1; ld_en = 1'b0; ld_a = 9'd0; ld_d = 32'd0; bus.memready = 1'b0;
        fn_tab[0] = 6'h20; fn_tab[1] = 6'h22; fn_tab[2] = 6'h24; fn_tab[3] = 6'h25; fn_tab[4] = 6'h2A;
        for (int i = 0; i < 512; i++) mmem[i] = 32'd0;
        model_reset();

        // Program image
        gen_a = 32'd0;
        for (int k = 0; k < 8; k++) emit(enc_i(6'h2B, 5'd0, 5'(k), 16'(32'h400 + 4 * k)));
        emit(enc_i(6'h08, 5'd0, 5'd1, 16'd5));
        emit(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD));
        emit(enc_r(5'd1, 5'd2, 5'd3, 6'h20));
        emit(enc_r(5'd1, 5'd2, 5'd4, 6'h22));
        emit(enc_r(5'd2, 5'd1, 5'd5, 6'h2A));
        emit(enc_r(5'd1, 5'd2, 5'd6, 6'h24));
        emit(enc_r(5'd1, 5'd2, 5'd7, 6'h25));
        for (int k = 3; k < 8; k++) emit(enc_i(6'h2B, 5'd0, 5'(k), 16'(32'h434 + 4 * k)));
        emit(enc_i(6'h08, 5'd0, 5'd0, 16'd7));
        emit(enc_i(6'h2B, 5'd0, 5'd0, 16'h0460));
        emit(enc_i(6'h08, 5'd0, 5'd1, 16'h0044));
        emit(enc_i(6'h2B, 5'd0, 5'd1, 16'h0008));
        emit(enc_i(6'h23, 5'd0, 5'd2, 16'h0008));
        emit(enc_i(6'h2B, 5'd0, 5'd2, 16'h0464));
        emit(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
        emit(enc_i(6'h08, 5'd0, 5'd10, 16'd1));
        emit(enc_i(6'h08, 5'd0, 5'd10, 16'd2));
        emit(enc_i(6'h04, 5'd1, 5'd0, 16'd2));
        emit({6'h02, 26'h40});
        emit(enc_i(6'h08, 5'd0, 5'd10, 16'd3));
        emit(enc_i(6'h08, 5'd0, 5'd10, 16'd4));
        gen_a = 32'h100;
        emit(enc_i(6'h3F, 5'd1, 5'd10, 16'h1234));
        emit(enc_r(5'd1, 5'd1, 5'd9, 6'h27));
        emit(enc_i(6'h2B, 5'd0, 5'd9, 16'h0468));
        emit(enc_i(6'h2B, 5'd0, 5'd10, 16'h046C));
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 5));
            r1 = 5'($urandom_range(0, 15));
            r2 = 5'($urandom_range(0, 15));
            r3 = 5'($urandom_range(1, 15));
            case (kind)
                0: emit(enc_i(6'h08, r1, r3, 16'($urandom)));
                2: emit(enc_i(6'h2B, 5'd0, r2, 16'(32'h480 + 4 * $urandom_range(0, 31))));
                3: emit(enc_i(6'h23, 5'd0, r3, 16'(32'h480 + 4 * $urandom_range(0, 31))));
                4: emit(enc_i(6'h04, r1, r2, 16'($urandom_range(0, 2))));
                default: emit(enc_r(r1, r2, r3, fn_tab[$urandom_range(0, 4)]));
            endcase
        end
        for (int k = 0; k < 16; k++) emit(enc_i(6'h2B, 5'd0, 5'(k), 16'(32'h500 + 4 * k)));
        end_pc = gen_a;

        // Load memory while the core is held in reset
        for (int w = 0; w < 512; w++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_a = 9'(w); ld_d = mmem[w];
        end
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_adr", bus.adr, 32'h0);
        chk1("reset_memread", bus.memread, 1'b1);
        chk1("reset_memwrite", bus.memwrite, 1'b0);
        chk("reset_pc", pc, 32'h0);
        chk1("reset_illegal", illegal, 1'b0);

        // First pass stops at the sw at 0x3C, which is then interrupted by reset
        n = 0;
        while (m_pc != 32'h3C && n < 100) begin
            exec_one(0, 0);
            n++;
        end
        bus.memready = 1'b1;
        repeat (3) @(negedge clk);
        chk1("midrst_memwrite", bus.memwrite, 1'b1);
        chk("midrst_adr", bus.adr, 32'h440);
        chk("midrst_data", bus.writedata, m_regs[3]);
        bus.memready = 1'b0;
        @(negedge clk);
        chk1("midrst_hold", bus.memwrite, 1'b1);
        reset = 1'b1;
        bus.memready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst2_adr", bus.adr, 32'h0);
        chk1("rst2_memread", bus.memread, 1'b1);
        chk1("rst2_memwrite", bus.memwrite, 1'b0);
        chk("rst2_pc", pc, 32'h0);
        chk("rst2_no_store", dmem[9'h110], mmem[9'h110]);
        model_reset();

        // Second pass: whole program, wait states on the sw at 0x5C and in the random section
        n = 0;
        while (m_pc < end_pc && n < 400) begin
            fw = 0; mw = 0;
            if (m_pc == 32'h5C) begin
                fw = 3; mw = 2;
            end else if (m_pc >= 32'h110) begin
                fw = int'($urandom_range(0, 2));
                mw = int'($urandom_range(0, 2));
            end
            exec_one(fw, mw);
            n++;
        end
        chk("run_reached_end", pc, end_pc);

        chk("alu_add", dmem[9'h110], 32'h2);
        chk("alu_sub", dmem[9'h111], 32'h8);
        chk("alu_slt", dmem[9'h112], 32'h1);
        chk("alu_and", dmem[9'h113], 32'h5);
        chk("alu_or", dmem[9'h114], 32'hFFFF_FFFD);
        chk("reg0_write", dmem[9'h118], 32'h0);
        chk("sw_mem8", dmem[9'h002], 32'h44);
        chk("lw_value", dmem[9'h119], 32'h44);
        chk("illegal_no_rd", dmem[9'h11A], 32'h0);
        chk("skipped_code", dmem[9'h11B], 32'h0);
        for (int w = 0; w < 512; w++) chk($sformatf("mem_%0h", w * 4), dmem[w], mmem[w]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
